// File: rtl/wishbone_ram_pkg.sv
// Shared types and defaults for the Wishbone RAM decoder
// (state encoding, error read data, timeout default, channel limit).
package wishbone_ram_pkg;

    localparam int          MAX_SRAM               = 8;
    localparam int          IDX_W                  = 3;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEFAULT_ERR_DATA       = 32'hdead_beef;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/wishbone_addr_decoder.sv
// Combinational mask/compare address decode; the lowest-index matching
// channel wins.
module wishbone_addr_decoder
    import wishbone_ram_pkg::*;
#(
    parameter int                      NUM_SRAM   = 2,
    parameter logic [32*NUM_SRAM-1:0]  BASE_ADDRS = {32'h3000_0400, 32'h3000_0000},
    parameter logic [32*NUM_SRAM-1:0]  ADDR_MASKS = {32'hffff_fe00, 32'hffff_ff00}
) (
    input  logic [31:0]      adr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest matching index is the last writer
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SRAM - 1; i >= 0; i--) begin
            if ((adr & ADDR_MASKS[32*i +: 32]) == BASE_ADDRS[32*i +: 32]) begin
                hit = 1'b1;
                idx = i[IDX_W-1:0];
            end else begin
                hit = hit;
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/wishbone_ram_decoder.sv
// Wishbone 1-to-N SRAM decoder with IDLE/ACTIVE/RESP handshake and
// registered outputs. Optional ACTIVE timeout: WB_RAM_DECODER_TIMEOUT_EN.
module wishbone_ram_decoder
    import wishbone_ram_pkg::*;
#(
    parameter int                      NUM_SRAM       = 2,
    parameter logic [32*NUM_SRAM-1:0]  BASE_ADDRS     = {32'h3000_0400, 32'h3000_0000},
    parameter logic [32*NUM_SRAM-1:0]  ADDR_MASKS     = {32'hffff_fe00, 32'hffff_ff00},
    parameter int                      TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0]             ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_ufp_stb_i,
    input  logic                     wbs_ufp_cyc_i,
    input  logic                     wbs_ufp_we_i,
    input  logic [3:0]               wbs_ufp_sel_i,
    input  logic [31:0]              wbs_ufp_adr_i,
    input  logic [31:0]              wbs_ufp_dat_i,
    output logic                     wbs_ufp_ack_o,
    output logic                     wbs_ufp_err_o,
    output logic [31:0]              wbs_ufp_dat_o,
    output logic [NUM_SRAM-1:0]      wbs_or_stb_o,
    output logic [NUM_SRAM-1:0]      wbs_or_cyc_o,
    output logic [NUM_SRAM-1:0]      wbs_or_we_o,
    output logic [4*NUM_SRAM-1:0]    wbs_or_sel_o,
    output logic [32*NUM_SRAM-1:0]   wbs_or_dat_o,
    output logic [31:0]              wbs_or_adr_o,
    input  logic [32*NUM_SRAM-1:0]   wbs_or_dat_i,
    input  logic [NUM_SRAM-1:0]      wbs_or_ack_i
);

    if (NUM_SRAM < 1 || NUM_SRAM > MAX_SRAM || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("wishbone_ram_decoder: parameter out of range");
    end

    state_t             state, state_next;
    logic [31:0]        adr_q, adr_next, wdat_q, wdat_next, rdata_q, rdata_next;
    logic               we_q, we_next, err_flag, err_flag_next;
    logic [3:0]         sel_q, sel_next;
    logic [IDX_W-1:0]   idx_q, idx_next, dec_idx;
    logic               dec_hit, sel_ack;
    logic [31:0]        sel_rdata;
    logic [NUM_SRAM-1:0]    stb_next, we_o_next;
    logic [4*NUM_SRAM-1:0]  sel_o_next;
    logic [32*NUM_SRAM-1:0] dat_o_next;
`ifdef WB_RAM_DECODER_TIMEOUT_EN
    logic [15:0]        cnt, cnt_next;
`endif

    wishbone_addr_decoder #(
        .NUM_SRAM   (NUM_SRAM),
        .BASE_ADDRS (BASE_ADDRS),
        .ADDR_MASKS (ADDR_MASKS)
    ) u_dec (
        .adr (wbs_ufp_adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    // Select the active channel's ack and read data; other channels are ignored
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SRAM; i++) begin
            if (idx_q == i[IDX_W-1:0]) begin
                sel_ack   = wbs_or_ack_i[i];
                sel_rdata = wbs_or_dat_i[32*i +: 32];
            end else begin
                sel_ack   = sel_ack;
                sel_rdata = sel_rdata;
            end
        end
    end

    // Next-state, captured fields and next registered output values
    always_comb begin
        state_next    = state;
        adr_next      = adr_q;
        wdat_next     = wdat_q;
        we_next       = we_q;
        sel_next      = sel_q;
        idx_next      = idx_q;
        rdata_next    = rdata_q;
        err_flag_next = err_flag;
`ifdef WB_RAM_DECODER_TIMEOUT_EN
        cnt_next      = cnt;
`endif
        case (state)
            IDLE: begin
                if (wbs_ufp_cyc_i && wbs_ufp_stb_i) begin
                    if (dec_hit) begin
                        adr_next      = wbs_ufp_adr_i;
                        wdat_next     = wbs_ufp_dat_i;
                        we_next       = wbs_ufp_we_i;
                        sel_next      = wbs_ufp_sel_i;
                        idx_next      = dec_idx;
                        err_flag_next = 1'b0;
                        state_next    = ACTIVE;
`ifdef WB_RAM_DECODER_TIMEOUT_EN
                        cnt_next      = 16'd0;
`endif
                    end else begin
                        rdata_next    = ERR_DATA;
                        err_flag_next = 1'b1;
                        state_next    = RESP;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            ACTIVE: begin
                if (!wbs_ufp_cyc_i) begin
                    state_next = IDLE;
                end else if (sel_ack) begin
                    rdata_next    = sel_rdata;
                    err_flag_next = 1'b0;
                    state_next    = RESP;
                end else begin
`ifdef WB_RAM_DECODER_TIMEOUT_EN
                    cnt_next = cnt + 16'd1;
                    if (cnt_next == 16'(TIMEOUT_CYCLES)) begin
                        rdata_next    = ERR_DATA;
                        err_flag_next = 1'b1;
                        state_next    = RESP;
                    end else begin
                        state_next = ACTIVE;
                    end
`else
                    state_next = ACTIVE;
`endif
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        stb_next   = '0;
        we_o_next  = '0;
        sel_o_next = '0;
        dat_o_next = '0;
        for (int i = 0; i < NUM_SRAM; i++) begin
            if (state_next == ACTIVE && idx_next == i[IDX_W-1:0]) begin
                stb_next[i]            = 1'b1;
                we_o_next[i]           = we_next;
                sel_o_next[4*i +: 4]   = sel_next;
                dat_o_next[32*i +: 32] = wdat_next;
            end else begin
                stb_next[i] = 1'b0;
            end
        end
    end

    // State, captured fields and registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            adr_q         <= '0;
            wdat_q        <= '0;
            we_q          <= 1'b0;
            sel_q         <= '0;
            idx_q         <= '0;
            rdata_q       <= '0;
            err_flag      <= 1'b0;
            wbs_ufp_ack_o <= 1'b0;
            wbs_ufp_err_o <= 1'b0;
            wbs_ufp_dat_o <= '0;
            wbs_or_stb_o  <= '0;
            wbs_or_cyc_o  <= '0;
            wbs_or_we_o   <= '0;
            wbs_or_sel_o  <= '0;
            wbs_or_dat_o  <= '0;
            wbs_or_adr_o  <= '0;
`ifdef WB_RAM_DECODER_TIMEOUT_EN
            cnt           <= 16'd0;
`endif
        end else begin
            state         <= state_next;
            adr_q         <= adr_next;
            wdat_q        <= wdat_next;
            we_q          <= we_next;
            sel_q         <= sel_next;
            idx_q         <= idx_next;
            rdata_q       <= rdata_next;
            err_flag      <= err_flag_next;
            wbs_ufp_ack_o <= (state_next == RESP);
            wbs_ufp_err_o <= (state_next == RESP) && err_flag_next;
            wbs_ufp_dat_o <= (state_next == RESP) ? rdata_next : 32'h0000_0000;
            wbs_or_stb_o  <= stb_next;
            wbs_or_cyc_o  <= stb_next;
            wbs_or_we_o   <= we_o_next;
            wbs_or_sel_o  <= sel_o_next;
            wbs_or_dat_o  <= dat_o_next;
            wbs_or_adr_o  <= adr_next;
`ifdef WB_RAM_DECODER_TIMEOUT_EN
            cnt           <= cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_wishbone_ram_decoder.sv
// Self-checking bench for wishbone_ram_decoder: directed scenarios plus
// randomized transactions against a decode/latency reference model.
module tb_wishbone_ram_decoder;

    localparam int          N        = 2;
    localparam int          TMO      = 255;
    localparam logic [31:0] ERR_WORD = 32'hdead_beef;
    localparam logic [31:0] BASE_TAB [N] = '{32'h3000_0000, 32'h3000_0400};
    localparam logic [31:0] MASK_TAB [N] = '{32'hffff_ff00, 32'hffff_fe00};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]      sel = 4'h0;
    logic [31:0]     adr = 32'h0, wdat = 32'h0;
    logic            ack_o, err_o;
    logic [31:0]     dat_o;
    logic [N-1:0]    or_stb, or_cyc, or_we;
    logic [4*N-1:0]  or_sel;
    logic [32*N-1:0] or_dat;
    logic [31:0]     or_adr;
    logic [32*N-1:0] or_dat_i = '0;
    logic [N-1:0]    or_ack_i = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wishbone_ram_decoder #(
        .NUM_SRAM       (N),
        .BASE_ADDRS     ({32'h3000_0400, 32'h3000_0000}),
        .ADDR_MASKS     ({32'hffff_fe00, 32'hffff_ff00}),
        .TIMEOUT_CYCLES (TMO),
        .ERR_DATA       (ERR_WORD)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_ufp_stb_i (stb),
        .wbs_ufp_cyc_i (cyc),
        .wbs_ufp_we_i  (we),
        .wbs_ufp_sel_i (sel),
        .wbs_ufp_adr_i (adr),
        .wbs_ufp_dat_i (wdat),
        .wbs_ufp_ack_o (ack_o),
        .wbs_ufp_err_o (err_o),
        .wbs_ufp_dat_o (dat_o),
        .wbs_or_stb_o  (or_stb),
        .wbs_or_cyc_o  (or_cyc),
        .wbs_or_we_o   (or_we),
        .wbs_or_sel_o  (or_sel),
        .wbs_or_dat_o  (or_dat),
        .wbs_or_adr_o  (or_adr),
        .wbs_or_dat_i  (or_dat_i),
        .wbs_or_ack_i  (or_ack_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: first table entry whose masked address matches.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & MASK_TAB[i]) == BASE_TAB[i]) return i;
        return -1;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, ".stb"}, 64'(or_stb), 64'h0);
        check({tag, ".cyc"}, 64'(or_cyc), 64'h0);
        check({tag, ".ack"}, 64'(ack_o), 64'h0);
        check({tag, ".dat"}, 64'(dat_o), 64'h0);
    endtask

    task automatic check_active(input string tag, input int ch, input logic [31:0] a,
                                input logic w, input logic [3:0] s, input logic [31:0] d);
        logic [N-1:0]    e_one = N'(1) << ch;
        logic [4*N-1:0]  e_sel = (4*N)'(s) << (4 * ch);
        logic [32*N-1:0] e_dat = (32*N)'(d) << (32 * ch);
        check({tag, ".stb"}, 64'(or_stb), 64'(e_one));
        check({tag, ".cyc"}, 64'(or_cyc), 64'(e_one));
        check({tag, ".we"},  64'(or_we),  w ? 64'(e_one) : 64'h0);
        check({tag, ".sel"}, 64'(or_sel), 64'(e_sel));
        check({tag, ".wdat"}, 64'(or_dat), 64'(e_dat));
        check({tag, ".adr"}, 64'(or_adr), 64'(a));
        check({tag, ".noack"}, 64'(ack_o), 64'h0);
    endtask

    // One full transaction; slave acks after 'waits' stall cycles. The request
    // stays asserted through the response cycle to prove no re-acceptance.
    task automatic run_txn(input string tag, input logic [31:0] a, input logic w,
                           input logic [3:0] s, input logic [31:0] d, input int waits,
                           input logic [31:0] rdata, input bit noise);
        int ch = ref_decode(a);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = a; we = w; sel = s; wdat = d;
        if (ch < 0) begin
            @(negedge clk);
            check({tag, ".miss_ack"}, 64'(ack_o), 64'h1);
            check({tag, ".miss_err"}, 64'(err_o), 64'h1);
            check({tag, ".miss_dat"}, 64'(dat_o), 64'(ERR_WORD));
            check({tag, ".miss_stb"}, 64'(or_stb), 64'h0);
        end else begin
            for (int k = 0; k <= waits; k++) begin
                @(negedge clk);
                or_ack_i = '0;
                check_active(tag, ch, a, w, s, d);
                if (noise && N > 1) begin
                    or_ack_i[(ch + 1) % N] = 1'b1;
                    or_dat_i[32*((ch + 1) % N) +: 32] = $urandom;
                end
                if (k == waits) begin
                    or_ack_i[ch] = 1'b1;
                    or_dat_i[32*ch +: 32] = rdata;
                end
            end
            @(negedge clk);
            or_ack_i = '0;
            or_dat_i = {$urandom, $urandom};
            check({tag, ".ack"}, 64'(ack_o), 64'h1);
            check({tag, ".err"}, 64'(err_o), 64'h0);
            check({tag, ".rdat"}, 64'(dat_o), 64'(rdata));
            check({tag, ".stb_off"}, 64'(or_stb), 64'h0);
        end
        @(negedge clk);
        check_quiet({tag, ".after"});
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] a, d, r;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check("reset.adr", 64'(or_adr), 64'h0);
        check("reset.err", 64'(err_o), 64'h0);
        rst = 1'b0;

        run_txn("wr_ch0", 32'h3000_0004, 1'b1, 4'hf, 32'h1234_5678, 0, 32'h0000_0000, 1'b0);
        run_txn("rd_ch1", 32'h3000_0410, 1'b0, 4'hf, 32'h0000_0000, 3, 32'ha5a5_a5a5, 1'b0);
        run_txn("miss",   32'h3000_0800, 1'b0, 4'hf, 32'h0000_0000, 0, 32'h0000_0000, 1'b0);

        // Abort by dropping cyc while ACTIVE; a late ack must be ignored
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0020; we = 1'b0; sel = 4'h3;
        @(negedge clk);
        check("abort.stb_on", 64'(or_stb), 64'h1);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check_quiet("abort.dropped");
        or_ack_i[0] = 1'b1; or_dat_i[31:0] = 32'h5555_0000;
        @(negedge clk);
        or_ack_i = '0;
        check_quiet("abort.late_ack");
        run_txn("post_abort", 32'h3000_0044, 1'b1, 4'h1, 32'h0bad_cafe, 1, 32'h1111_2222, 1'b0);

        // Reset mid-transaction with a pending slave ack
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0500; we = 1'b1; sel = 4'hc; wdat = 32'hfeed_f00d;
        @(negedge clk);
        check("rstmid.stb_on", 64'(or_stb), 64'h2);
        rst = 1'b1; or_ack_i[1] = 1'b1; or_dat_i[63:32] = 32'h7777_7777;
        @(negedge clk);
        check_quiet("rstmid.reset");
        check("rstmid.adr", 64'(or_adr), 64'h0);
        rst = 1'b0; or_ack_i = '0; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check_quiet("rstmid.idle");
        run_txn("post_rst", 32'h3000_05fc, 1'b0, 4'hf, 32'h0, 2, 32'h8642_1357, 1'b0);

`ifdef WB_RAM_DECODER_TIMEOUT_EN
        // Slave never acks: stb for TMO cycles, then error response
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0008; we = 1'b0; sel = 4'hf;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            check_active("tmo", 0, 32'h3000_0008, 1'b0, 4'hf, wdat);
        end
        @(negedge clk);
        check("tmo.ack", 64'(ack_o), 64'h1);
        check("tmo.err", 64'(err_o), 64'h1);
        check("tmo.dat", 64'(dat_o), 64'(ERR_WORD));
        check("tmo.stb", 64'(or_stb), 64'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
`else
        // Without a timeout the request stalls as long as the slave does
        run_txn("stall300", 32'h3000_0008, 1'b0, 4'hf, 32'h0, 300, 32'hc0de_0300, 1'b0);
`endif

        for (int t = 0; t < 40; t++) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom : (32'h3000_0000 | ($urandom & 32'h0000_0fff));
            d = $urandom;
            r = $urandom;
            run_txn("rand", a, 1'($urandom), 4'($urandom), d, $urandom_range(0, 5), r, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wishbone_ram_decoder.md
WISHBONE_RAM_DECODER -- requirements
Module: wishbone_ram_decoder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_SRAM, 2, number of downstream SRAM Wishbone channels (1..8).
  BASE_ADDRS, {32'h3000_0400, 32'h3000_0000}, packed NUM_SRAM x 32 base addresses; channel i in bits [32i+31:32i].
  ADDR_MASKS, {32'hffff_fe00, 32'hffff_ff00}, packed NUM_SRAM x 32 decode masks; same packing.
  TIMEOUT_CYCLES, 255, ACTIVE cycles allowed before error termination (2..65535).
  ERR_DATA, 32'hdead_beef, read data returned on error termination.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  wb_clk_i  in  1  clock.
  wb_rst_i  in  1  reset.
  wbs_ufp_stb_i / wbs_ufp_cyc_i / wbs_ufp_we_i  in  1 each  upstream strobe, cycle, write enable.
  wbs_ufp_sel_i  in  4  byte selects.
  wbs_ufp_adr_i / wbs_ufp_dat_i  in  32 each  address, write data.
  wbs_ufp_ack_o  out  1  upstream acknowledge.
  wbs_ufp_err_o  out  1  upstream error, asserted together with ack.
  wbs_ufp_dat_o  out  32  upstream read data.
  wbs_or_stb_o / wbs_or_cyc_o / wbs_or_we_o  out  NUM_SRAM each  per-channel strobe, cycle, write enable.
  wbs_or_sel_o  out  4*NUM_SRAM  per-channel byte selects.
  wbs_or_dat_o  out  32*NUM_SRAM  per-channel write data.
  wbs_or_adr_o  out  32  registered address, shared by all channels.
  wbs_or_dat_i  in  32*NUM_SRAM  per-channel read data.
  wbs_or_ack_i  in  NUM_SRAM  per-channel acknowledge.
REQ-003 One clock, wb_clk_i; reset wb_rst_i SHALL be synchronous and active-high.

Function
REQ-004 Channel i hits when (wbs_ufp_adr_i & mask_i) == base_i; the lowest-index hitting channel SHALL win.
REQ-005 FSM states SHALL be IDLE, ACTIVE, RESP.
REQ-006 IDLE with cyc_i & stb_i: on hit, register address, we, sel, write data and channel index, then enter ACTIVE; on miss, enter RESP with error flag set.
REQ-007 In ACTIVE, only the selected channel SHALL drive stb/cyc = 1 with registered we/sel/dat; every other channel's outputs SHALL be all zero.
REQ-008 In ACTIVE, selected ack_i = 1 SHALL capture that channel's dat_i, deassert downstream stb/cyc on the next edge and enter RESP.
REQ-009 Acks from non-selected channels, or received outside ACTIVE, SHALL be ignored.
REQ-010 In RESP, wbs_ufp_ack_o SHALL be 1 for exactly one cycle, with err_o = error flag and dat_o = captured data (ERR_DATA on error); the FSM then returns to IDLE.
REQ-011 Minimum latency: request in cycle 0, downstream stb in cycle 1, same-cycle slave ack gives upstream ack in cycle 2.
REQ-012 wbs_ufp_cyc_i = 0 while in ACTIVE SHALL abort: downstream outputs zero on the next edge, return to IDLE, no upstream ack.
REQ-013 wbs_ufp_dat_o SHALL be 0 whenever ack_o = 0.
REQ-014 A new request SHALL be accepted only in IDLE; upstream stb held high through RESP SHALL NOT start a second transaction until IDLE is re-entered.

Reset
REQ-015 While wb_rst_i = 1, FSM = IDLE, all outputs 0, timeout counter 0 and error flag 0 at the next edge, including mid-transaction; a pending slave ack SHALL be discarded.

Configuration
REQ-016 Macro WB_RAM_DECODER_TIMEOUT_EN defined: a 16-bit counter cleared on ACTIVE entry and incremented each ACTIVE cycle; reaching TIMEOUT_CYCLES without ack SHALL drop downstream outputs and enter RESP with error flag set.
REQ-017 Macro WB_RAM_DECODER_TIMEOUT_EN undefined: no counter logic; ACTIVE waits indefinitely for ack or cyc_i drop.

Structure
REQ-018 Package wishbone_ram_pkg SHALL hold the state enum, default ERR_DATA and TIMEOUT_CYCLES constants, and the maximum channel count.
REQ-019 Sub-module wishbone_addr_decoder SHALL contain the combinational mask/compare priority decode, outputting hit and index.

Verification
REQ-020 Write 0x1234_5678 to 0x3000_0004, slave 0 acks in cycle 1 -> only channel 0 stb; upstream ack in cycle 2, err = 0.
REQ-021 Read 0x3000_0410, slave 1 returns 0xa5a5_a5a5 after 3 wait cycles -> dat_o = 0xa5a5_a5a5 with a single ack pulse; channel 0 outputs stay zero.
REQ-022 Access 0x3000_0800 (no hit) -> ack and err high in cycle 1, dat_o = 0xdead_beef, no downstream stb.
REQ-023 With TIMEOUT_EN and TIMEOUT_CYCLES = 4, slave never acks -> downstream stb high 4 cycles, then ack+err with 0xdead_beef; without the macro, stb held through 300 cycles.
REQ-024 Drop cyc_i in ACTIVE, or assert wb_rst_i in ACTIVE -> downstream zero next cycle, no upstream ack, a late slave ack is ignored, and the next request completes normally.
